// File: rtl/booth_radix4_multiplier_pkg.sv
// Shared constants and encodings for the radix-4 Booth multiplier, its controller and bench.
package booth_radix4_multiplier_pkg;

    localparam int unsigned SIZE = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } sel_t;

    // Group is {Q[1], Q[0], q_m1}
    function automatic sel_t recode_sel(input logic [2:0] grp);
        sel_t sel;
        case (grp)
            3'b001, 3'b010: sel = P1;
            3'b011:         sel = P2;
            3'b100:         sel = M2;
            3'b101, 3'b110: sel = M1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_radix4_multiplier_if
    import booth_radix4_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = SIZE
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_mode, multiplier, multiplicand,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_mode, multiplier, multiplicand,
        output busy, done, result
    );
endinterface

// File: rtl/booth_radix4_recoder.sv
// Radix-4 Booth digit recoder: maps a 3-bit group to the signed addend 0/±M/±2M.
module booth_radix4_recoder
    import booth_radix4_multiplier_pkg::*;
#(
    parameter int unsigned N = SIZE + 2
) (
    input  logic [2:0]   group,
    input  logic [N-1:0] m,
    output logic [N:0]   addend
);
    logic [N:0] m1;
    logic [N:0] m2;

    // M is already sign-extended from WIDTH bits, so 2M fits in N+1 bits
    assign m1 = {m[N-1], m};
    assign m2 = {m, 1'b0};

    always_comb begin
        addend = '0;
        case (recode_sel(group))
            P1:      addend = m1;
            P2:      addend = m2;
            M1:      addend = -m1;
            M2:      addend = -m2;
            default: addend = '0;
        endcase
    end
endmodule

// File: rtl/booth_radix4_multiplier.sv
// Multi-cycle radix-4 Booth multiplier, signed/unsigned per operation, WIDTH/2+1 iterations.
module booth_radix4_multiplier
    import booth_radix4_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    booth_radix4_multiplier_if.slave   bus
);
    localparam int unsigned N  = WIDTH + 2;
    localparam int unsigned K  = N / 2;
    localparam int unsigned CW = $clog2(K + 1);

    state_t state;
    state_t state_next;
    logic   accept;

    logic [N-1:0]       m_reg;
    logic [N-1:0]       q_reg;
    logic [N:0]         a_reg;
    logic               q_m1;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] result_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [N-1:0]       mcand_ext;
    logic [N-1:0]       mplier_ext;
    logic [N:0]         addend;
    logic [N:0]         a_sum;
    logic [2*N+1:0]     shifted;

    assign mcand_ext  = {{2{bus.signed_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    assign mplier_ext = {{2{bus.signed_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};

    booth_radix4_recoder #(.N(N)) u_recoder (
        .group  ({q_reg[1:0], q_m1}),
        .m      (m_reg),
        .addend (addend)
    );

    assign a_sum   = a_reg + addend;
    assign shifted = $signed({a_sum, q_reg, q_m1}) >>> 2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) state_next = DONE;
            end
            DONE: begin
                accept     = bus.start;
                state_next = bus.start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg      <= '0;
            q_reg      <= '0;
            a_reg      <= '0;
            q_m1       <= 1'b0;
            cnt        <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            busy_reg <= (state_next == CALC);
            done_reg <= (state_next == DONE);
            if (accept) begin
                m_reg <= mcand_ext;
                q_reg <= mplier_ext;
                a_reg <= '0;
                q_m1  <= 1'b0;
                cnt   <= CW'(K);
            end else if (state == CALC) begin
                a_reg <= shifted[2*N+1:N+1];
                q_reg <= shifted[N:1];
                q_m1  <= shifted[0];
                cnt   <= cnt - CW'(1);
                // Product is taken from the post-shift {A,Q} of the final iteration
                if (cnt == CW'(1)) result_reg <= shifted[2*WIDTH:1];
            end
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier at WIDTH=8 and WIDTH=16.
module tb_booth_radix4_multiplier;
    import booth_radix4_multiplier_pkg::*;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    booth_radix4_multiplier_if #(.WIDTH(8))  bus8 ();
    booth_radix4_multiplier_if #(.WIDTH(16)) bus16 ();

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue on the 8-bit DUT in the current cycle, then check cycles 1..6; ends in the done cycle
    task automatic run8(input string tag, input logic sm, input logic [7:0] mplier,
                        input logic [7:0] mcand, input logic [15:0] exp, input logic [15:0] prior);
        bus8.start        = 1'b1;
        bus8.signed_mode  = sm;
        bus8.multiplier   = mplier;
        bus8.multiplicand = mcand;
        tick();
        bus8.start        = 1'b0;
        bus8.signed_mode  = ~sm;
        bus8.multiplier   = ~mplier;
        bus8.multiplicand = mcand ^ 8'h5A;
        for (int unsigned c = 1; c <= 5; c++) begin
            chk({tag, "_busy"},   32'(bus8.busy),   32'd1);
            chk({tag, "_nodone"}, 32'(bus8.done),   32'd0);
            chk({tag, "_held"},   32'(bus8.result), 32'(prior));
            tick();
        end
        chk({tag, "_done"},   32'(bus8.done),   32'd1);
        chk({tag, "_idle"},   32'(bus8.busy),   32'd0);
        chk({tag, "_result"}, 32'(bus8.result), 32'(exp));
    endtask

    task automatic run16(input string tag, input logic sm, input logic [15:0] mplier,
                         input logic [15:0] mcand, input logic [31:0] exp);
        bus16.start        = 1'b1;
        bus16.signed_mode  = sm;
        bus16.multiplier   = mplier;
        bus16.multiplicand = mcand;
        tick();
        bus16.start        = 1'b0;
        for (int unsigned c = 1; c <= 9; c++) begin
            chk({tag, "_busy"},   32'(bus16.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus16.done), 32'd0);
            tick();
        end
        chk({tag, "_done"},   32'(bus16.done),   32'd1);
        chk({tag, "_result"}, bus16.result,      exp);
        tick();
        chk({tag, "_pulse"},  32'(bus16.done),   32'd0);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus8.start = 1'b0;  bus8.signed_mode = 1'b0;
        bus8.multiplier = '0; bus8.multiplicand = '0;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0;
        bus16.multiplier = '0; bus16.multiplicand = '0;

        tick();
        tick();
        chk("rst_busy",   32'(bus8.busy),   32'd0);
        chk("rst_done",   32'(bus8.done),   32'd0);
        chk("rst_result", 32'(bus8.result), 32'd0);
        chk("rst_res16",  bus16.result,     32'd0);
        rst = 1'b1;
        tick();

        // -128 x -128 signed
        run8("neg128sq", 1'b1, 8'h80, 8'h80, 16'h4000, 16'h0000);
        tick();
        chk("neg128sq_pulse", 32'(bus8.done),   32'd0);
        chk("neg128sq_hold",  32'(bus8.result), 32'h4000);

        run8("ffu", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'h4000);
        tick();
        run8("ffs", 1'b1, 8'hFF, 8'hFF, 16'h0001, 16'hFE01);
        tick();
        run8("127xm128", 1'b1, 8'h80, 8'h7F, 16'hC080, 16'h0001);
        tick();

        // Back-to-back: second start issued in the done cycle of the first
        run8("ffx01u", 1'b0, 8'h01, 8'hFF, 16'h00FF, 16'hC080);
        run8("b2b_3x5", 1'b1, 8'h05, 8'h03, 16'h000F, 16'h00FF);
        tick();
        chk("b2b_pulse", 32'(bus8.done), 32'd0);

        // Start pulsed in cycle 2 of a running op must be ignored
        bus8.start = 1'b1; bus8.signed_mode = 1'b0;
        bus8.multiplier = 8'h0C; bus8.multiplicand = 8'h0B;
        tick();
        bus8.start = 1'b0;
        tick();
        bus8.start = 1'b1; bus8.multiplier = 8'h03; bus8.multiplicand = 8'h03;
        tick();
        bus8.start = 1'b0;
        for (int unsigned c = 3; c <= 11; c++) begin
            chk("ign_done", 32'(bus8.done), (c == 6) ? 32'd1 : 32'd0);
            if (c == 6) chk("ign_result", 32'(bus8.result), 32'h0084);
            tick();
        end
        chk("ign_hold", 32'(bus8.result), 32'h0084);

        // Asynchronous reset in cycle 3 of a running op
        bus8.start = 1'b1; bus8.signed_mode = 1'b0;
        bus8.multiplier = 8'h55; bus8.multiplicand = 8'h33;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        chk("mid_busy", 32'(bus8.busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy",   32'(bus8.busy),   32'd0);
        chk("arst_done",   32'(bus8.done),   32'd0);
        chk("arst_result", 32'(bus8.result), 32'd0);
        tick();
        rst = 1'b1;
        for (int unsigned c = 0; c < 8; c++) begin
            chk("arst_nodone", 32'(bus8.done), 32'd0);
            chk("arst_nobusy", 32'(bus8.busy), 32'd0);
            tick();
        end
        run8("0fx0f", 1'b0, 8'h0F, 8'h0F, 16'h00E1, 16'h0000);
        tick();

        run16("w16_min", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run16("w16_ffu", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_radix4_multiplier.md
# booth_radix4_multiplier

Parametrised, multi-cycle radix-4 (modified) Booth multiplier. It is the successor to the team's radix-2 sequential Booth multiplier and halves the iteration count. It adds a per-operation signed/unsigned mode and a start/busy/done handshake, and holds the result until it is overwritten. It sits as an arithmetic slave under a controller that issues one multiply at a time.

## Interface
Parameters:
- `WIDTH`, default `` `size `` (8): operand width; must be even and ≥ 4.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Reset, asynchronous, active-low.
- `start`: input, 1 bit. Request a multiply; accepted only when `busy`=0.
- `signed_mode`: input, 1 bit. 1 = two's-complement operands, 0 = unsigned. Sampled at accept.
- `multiplier`: input, `WIDTH` bits. Sampled at accept.
- `multiplicand`: input, `WIDTH` bits. Sampled at accept.
- `busy`: output, 1 bit. High while in CALC.
- `done`: output, 1 bit. One-cycle pulse when `result` is updated.
- `result`: output, 2·`WIDTH` bits. Last product; held until the next `done`.

## Operation
- Extension: operands are extended to N = `WIDTH`+2 bits. Sign extension when `signed_mode`=1, zero extension otherwise. One datapath serves both modes.
- Iteration count: K = N/2 = `WIDTH`/2+1.
- Registers:
  - M: N bits, extended multiplicand.
  - A: N+1 bits, accumulator, so that ±2M fits.
  - Q: N bits, extended multiplier.
  - q_m1: 1 bit.
  - cnt: ⌈log2(K+1)⌉ bits.
- Iteration step:
  - Recode {Q[1:0], q_m1] as follows: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - A ← A + recoded value, in two's complement with M sign-extended.
  - Then arithmetic-shift {A, Q, q_m1} right by 2.
- Product: after K iterations, `result` ← low 2·`WIDTH` bits of {A, Q}. This is exact in both modes; no overflow is possible.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if `start`=1, latch operands and mode, set A=0, q_m1=0, cnt=K, and go to CALC.
  - CALC: perform one iteration per cycle and decrement cnt. On the edge where cnt=1, load `result` and go to DONE.
  - DONE: `done`=1. If `start`=1, accept a new operation exactly as in IDLE (back-to-back) and go to CALC. Otherwise go to IDLE.
- `start` while `busy`=1 is ignored and is not queued.
- Changing operand inputs after accept has no effect on the running operation.
- Reset, asynchronous at any time, including mid-CALC:
  - State goes to IDLE.
  - All registers, `result`, `busy` and `done` are cleared to 0.
  - No `done` is produced for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0.
- Sequence, with `start` high in cycle 0 (sampled at edge 1):
  - Cycles 1…K: CALC, `busy`=1.
  - Cycle K+1: `done`=1, `busy`=0, new `result` visible.
- Latency is K+1 cycles from the start cycle to `done`. For `WIDTH`=8 this is 6.
- Throughput is one product per K+1 cycles when `start` is asserted during DONE.
- `result` changes only on the edge that enters DONE. It is stable at all other times.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared constants include (`` `size ``) supplies the default `WIDTH`.
- Put FSM state encodings and the Booth recode-select encoding (ZERO, P1, P2, M1, M2) in the same shared include, so that the controller and the verification bench use identical names.
- One combinational sub-module, `booth_radix4_recoder`:
  - Inputs: 3-bit group and M.
  - Output: the N+1-bit signed addend.
- FSM, counter and shift registers stay in the top module.

## Test plan
1. `WIDTH`=8, signed, multiplicand=−128 (0x80), multiplier=−128 → `result`=0x4000, `done` in cycle 6, `busy` high in cycles 1–5 only.
2. `WIDTH`=8, unsigned, 0xFF × 0xFF → 0xFE01. Then the same operands signed (−1 × −1) → 0x0001.
3. `WIDTH`=8, signed, 0x7F × 0x80 (127 × −128) → 0xC080. Unsigned 0xFF × 0x01 → 0x00FF.
4. Back-to-back:
   - Assert `start` during DONE with 3 × 5 signed.
   - Required: the next `done` comes 6 cycles later with `result`=0x000F.
   - The prior `result` is held until then.
5. `start` pulsed in cycle 2 of a running operation, with different operands:
   - Required: it is ignored; only one `done` occurs, and it carries the first operands' product.
6. `rst` driven low mid-CALC (cycle 3):
   - Required: `busy`, `done` and `result` read 0 immediately (asynchronous); no `done` afterwards.
   - A fresh start of 0x0F × 0x0F unsigned then yields 0x00E1.
   - Repeat with `WIDTH`=16: 0x8000 × 0x8000 signed → 0x40000000.
